uc_multiciclo: RTL and testbench



---
 rtl/uc_pkg.sv | 39 +++
 rtl/uc_decoder.sv | 34 +++
 rtl/uc_multiciclo.sv | 134 +++++++++++++
 tb/tb_uc_multiciclo.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uc_pkg.sv
// Shared types and encodings for the multi-cycle control unit and its decoder.
package uc_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_WB     = 3'd4,
      ST_HALT   = 3'd5
   } state_e;

   // CLS_ILLEGAL is the all-zero encoding so a cleared class register reads as illegal
   typedef enum logic [2:0] {
      CLS_ILLEGAL = 3'd0,
      CLS_LOAD    = 3'd1,
      CLS_STORE   = 3'd2,
      CLS_OPIMM   = 3'd3,
      CLS_OP      = 3'd4,
      CLS_BRANCH  = 3'd5
   } class_e;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   localparam logic [1:0] OPM_REG = 2'd0;
   localparam logic [1:0] OPM_MEM = 2'd1;
   localparam logic [1:0] OPM_IMM = 2'd2;

   localparam logic [2:0] SEL_NOBR = 3'd7;

   function automatic logic is_branch_f3(input logic [2:0] f3);
      return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd4) || (f3 == 3'd5);
   endfunction

endpackage

// File: rtl/uc_decoder.sv
// Combinational decode of opcode/funct3/funct7_5 into instruction class and sub-op.
module uc_decoder
   import uc_pkg::*;
#(
   parameter int OPCODE_W = 7
) (
   input  logic [OPCODE_W-1:0] opcode,
   input  logic [2:0]          funct3,
   input  logic                funct7_5,
   output class_e              cls_o,
   output logic [2:0]          br_sel_o,
   output logic                sub_o
);

   always_comb begin
      cls_o    = CLS_ILLEGAL;
      br_sel_o = SEL_NOBR;
      sub_o    = 1'b0;
      if (opcode == OPCODE_W'(OPC_LOAD) && funct3 == 3'd3) begin
         cls_o = CLS_LOAD;
      end else if (opcode == OPCODE_W'(OPC_STORE) && funct3 == 3'd3) begin
         cls_o = CLS_STORE;
      end else if (opcode == OPCODE_W'(OPC_OPIMM) && funct3 == 3'd0) begin
         cls_o = CLS_OPIMM;
      end else if (opcode == OPCODE_W'(OPC_OP) && funct3 == 3'd0) begin
         cls_o = CLS_OP;
         sub_o = funct7_5;
      end else if (opcode == OPCODE_W'(OPC_BRANCH) && is_branch_f3(funct3)) begin
         cls_o    = CLS_BRANCH;
         br_sel_o = funct3;
      end
   end

endmodule

// File: rtl/uc_multiciclo.sv
// Multi-cycle sequencer for the Instruction_FD datapath (ld, sd, addi, add/sub, branches).
// Optional: define UC_HALT_ON_ILLEGAL_EN to stop in HALT on an illegal instruction.
module uc_multiciclo
   import uc_pkg::*;
#(
   parameter int OPCODE_W = 7,
   parameter int STATE_W  = 3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic [2:0]          funct3,
   input  logic                funct7_5,
   output logic                WE_mem,
   output logic                WE_reg,
   output logic [1:0]          OP_MEM_I,
   output logic                ADD_SUB,
   output logic                PC_load,
   output logic                IR_load,
   output logic [2:0]          select_flags,
   output logic                halted,
   output logic [STATE_W-1:0]  state_o
);

   state_e     state_q, state_d;
   class_e     cls_q, cls_d;
   logic [2:0] sel_q, sel_d;
   logic       sub_q, sub_d;

   class_e     dec_cls;
   logic [2:0] dec_sel;
   logic       dec_sub;

   uc_decoder #(.OPCODE_W(OPCODE_W)) u_decoder (
      .opcode   (opcode),
      .funct3   (funct3),
      .funct7_5 (funct7_5),
      .cls_o    (dec_cls),
      .br_sel_o (dec_sel),
      .sub_o    (dec_sub)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cls_q   <= CLS_ILLEGAL;
         sel_q   <= SEL_NOBR;
         sub_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cls_q   <= cls_d;
         sel_q   <= sel_d;
         sub_q   <= sub_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cls_d        = cls_q;
      sel_d        = sel_q;
      sub_d        = sub_q;
      WE_mem       = 1'b0;
      WE_reg       = 1'b0;
      OP_MEM_I     = OPM_REG;
      ADD_SUB      = 1'b0;
      PC_load      = 1'b0;
      IR_load      = 1'b0;
      select_flags = SEL_NOBR;

      case (state_q)
         ST_IDLE:  state_d = ST_FETCH;
         ST_FETCH: begin
            IR_load = 1'b1;
            state_d = ST_DECODE;
         end
         ST_DECODE: begin
            // Capture the IR-derived fields here so EXEC/WB ignore later IR changes
            cls_d = dec_cls;
            sel_d = dec_sel;
            sub_d = dec_sub;
`ifdef UC_HALT_ON_ILLEGAL_EN
            state_d = (dec_cls == CLS_ILLEGAL) ? ST_HALT : ST_EXEC;
`else
            state_d = ST_EXEC;
`endif
         end
         ST_EXEC: begin
            state_d = (cls_q == CLS_LOAD) ? ST_WB : ST_FETCH;
            case (cls_q)
               CLS_LOAD: OP_MEM_I = OPM_MEM;
               CLS_STORE: begin
                  OP_MEM_I = OPM_MEM;
                  WE_mem   = 1'b1;
                  PC_load  = 1'b1;
               end
               CLS_OPIMM: begin
                  OP_MEM_I = OPM_IMM;
                  WE_reg   = 1'b1;
                  PC_load  = 1'b1;
               end
               CLS_OP: begin
                  OP_MEM_I = OPM_REG;
                  WE_reg   = 1'b1;
                  ADD_SUB  = sub_q;
                  PC_load  = 1'b1;
               end
               CLS_BRANCH: begin
                  ADD_SUB      = 1'b1;
                  select_flags = sel_q;
                  PC_load      = 1'b1;
               end
               default: PC_load = 1'b1;
            endcase
         end
         ST_WB: begin
            OP_MEM_I = OPM_MEM;
            WE_reg   = 1'b1;
            PC_load  = 1'b1;
            state_d  = ST_FETCH;
         end
         ST_HALT:  state_d = ST_HALT;
         default:  state_d = ST_IDLE;
      endcase
   end

`ifdef UC_HALT_ON_ILLEGAL_EN
   assign halted = (state_q == ST_HALT);
`else
   assign halted = 1'b0;
`endif

   assign state_o = STATE_W'(state_q);

endmodule

// File: tb/tb_uc_multiciclo.sv
// Directed-vector bench for uc_multiciclo; outputs are packed into one vector per cycle.
module tb_uc_multiciclo;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [6:0] opcode = 7'b0010011;
   logic [2:0] funct3 = 3'd0;
   logic       funct7_5 = 1'b0;
   logic       WE_mem, WE_reg, ADD_SUB, PC_load, IR_load, halted;
   logic [1:0] OP_MEM_I;
   logic [2:0] select_flags;
   logic [2:0] state_o;

   int checks = 0;
   int fails = 0;

   uc_multiciclo #(.OPCODE_W(7), .STATE_W(3)) dut (
      .clk          (clk),
      .reset        (reset),
      .opcode       (opcode),
      .funct3       (funct3),
      .funct7_5     (funct7_5),
      .WE_mem       (WE_mem),
      .WE_reg       (WE_reg),
      .OP_MEM_I     (OP_MEM_I),
      .ADD_SUB      (ADD_SUB),
      .PC_load      (PC_load),
      .IR_load      (IR_load),
      .select_flags (select_flags),
      .halted       (halted),
      .state_o      (state_o)
   );

   always #5 clk = ~clk;

   // {WE_mem, WE_reg, OP_MEM_I, ADD_SUB, PC_load, IR_load, select_flags, halted}
   wire [10:0] outs = {WE_mem, WE_reg, OP_MEM_I, ADD_SUB, PC_load, IR_load, select_flags, halted};

   localparam logic [10:0] E_QUIET = {1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 3'd7, 1'b0};
   localparam logic [10:0] E_FETCH = {1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 3'd7, 1'b0};
   localparam logic [10:0] E_LDEX  = {1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 3'd7, 1'b0};
   localparam logic [10:0] E_LDWB  = {1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 3'd7, 1'b0};
   localparam logic [10:0] E_SUB   = {1'b0, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 3'd7, 1'b0};
   localparam logic [10:0] E_ADD   = {1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 3'd7, 1'b0};
   localparam logic [10:0] E_SD    = {1'b1, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0, 3'd7, 1'b0};
   localparam logic [10:0] E_ADDI  = {1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 3'd7, 1'b0};
   localparam logic [10:0] E_NOP   = {1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 3'd7, 1'b0};
   localparam logic [10:0] E_HALT  = {1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 3'd7, 1'b1};

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      opcode = 7'b0010011; funct3 = 3'd0; funct7_5 = 1'b0;
      step();
      checks++;
      if (state_o !== 3'd0 || outs !== E_QUIET) begin
         fails++; $display("FAIL rst_cycle1: state=%0d outs=%b want state=0 outs=%b", state_o, outs, E_QUIET);
      end
      step();
      checks++;
      if (state_o !== 3'd0 || outs !== E_QUIET) begin
         fails++; $display("FAIL rst_cycle2: state=%0d outs=%b want state=0 outs=%b", state_o, outs, E_QUIET);
      end
      reset = 1'b0;
      step();
      checks++;
      if (state_o !== 3'd1 || outs !== E_FETCH) begin
         fails++; $display("FAIL rst_fetch: state=%0d outs=%b want state=1 outs=%b", state_o, outs, E_FETCH);
      end
      step();
      checks++;
      if (state_o !== 3'd2 || outs !== E_QUIET) begin
         fails++; $display("FAIL rst_decode: state=%0d outs=%b want state=2 outs=%b", state_o, outs, E_QUIET);
      end
      step();
      checks++;
      if (state_o !== 3'd3 || outs !== E_ADDI) begin
         fails++; $display("FAIL rst_addi_exec: state=%0d outs=%b want state=3 outs=%b", state_o, outs, E_ADDI);
      end
      step();
      checks++;
      if (state_o !== 3'd1 || outs !== E_FETCH) begin
         fails++; $display("FAIL rst_refetch: state=%0d outs=%b want state=1 outs=%b", state_o, outs, E_FETCH);
      end
   endtask

   // Entered with the FSM in FETCH; ends in the next FETCH
   task automatic test_load();
      opcode = 7'b0000011; funct3 = 3'd3; funct7_5 = 1'b0;
      step();
      checks++;
      if (state_o !== 3'd2 || outs !== E_QUIET) begin
         fails++; $display("FAIL ld_decode: state=%0d outs=%b want state=2 outs=%b", state_o, outs, E_QUIET);
      end
      step();
      checks++;
      if (state_o !== 3'd3 || outs !== E_LDEX) begin
         fails++; $display("FAIL ld_exec: state=%0d outs=%b want state=3 outs=%b", state_o, outs, E_LDEX);
      end
      step();
      checks++;
      if (state_o !== 3'd4 || outs !== E_LDWB) begin
         fails++; $display("FAIL ld_wb: state=%0d outs=%b want state=4 outs=%b", state_o, outs, E_LDWB);
      end
      step();
      checks++;
      if (state_o !== 3'd1 || outs !== E_FETCH) begin
         fails++; $display("FAIL ld_next_fetch: state=%0d outs=%b want state=1 outs=%b", state_o, outs, E_FETCH);
      end
   endtask

   task automatic test_op_latch();
      opcode = 7'b0110011; funct3 = 3'd0; funct7_5 = 1'b1;
      step();
      step();
      funct7_5 = 1'b0;
      opcode = 7'b1111111;
      #1;
      checks++;
      if (state_o !== 3'd3 || outs !== E_SUB) begin
         fails++; $display("FAIL sub_latched: state=%0d outs=%b want state=3 outs=%b", state_o, outs, E_SUB);
      end
      step();
      checks++;
      if (state_o !== 3'd1 || outs !== E_FETCH) begin
         fails++; $display("FAIL sub_next_fetch: state=%0d outs=%b want state=1 outs=%b", state_o, outs, E_FETCH);
      end
      opcode = 7'b0110011; funct3 = 3'd0; funct7_5 = 1'b0;
      step();
      step();
      checks++;
      if (state_o !== 3'd3 || outs !== E_ADD) begin
         fails++; $display("FAIL add_exec: state=%0d outs=%b want state=3 outs=%b", state_o, outs, E_ADD);
      end
      step();
   endtask

   task automatic test_store_addi();
      opcode = 7'b0100011; funct3 = 3'd3;
      step();
      step();
      checks++;
      if (state_o !== 3'd3 || outs !== E_SD) begin
         fails++; $display("FAIL sd_exec: state=%0d outs=%b want state=3 outs=%b", state_o, outs, E_SD);
      end
      step();
      opcode = 7'b0010011; funct3 = 3'd0;
      step();
      step();
      checks++;
      if (state_o !== 3'd3 || outs !== E_ADDI) begin
         fails++; $display("FAIL addi_exec: state=%0d outs=%b want state=3 outs=%b", state_o, outs, E_ADDI);
      end
      step();
      checks++;
      if (state_o !== 3'd1 || outs !== E_FETCH) begin
         fails++; $display("FAIL addi_next_fetch: state=%0d outs=%b want state=1 outs=%b", state_o, outs, E_FETCH);
      end
   endtask

   task automatic test_branch();
      logic [2:0]  f3_tab [4];
      logic [10:0] exp;
      f3_tab[0] = 3'd0; f3_tab[1] = 3'd5; f3_tab[2] = 3'd1; f3_tab[3] = 3'd4;
      for (int i = 0; i < 4; i++) begin
         opcode = 7'b1100011; funct3 = f3_tab[i];
         exp = {1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, f3_tab[i], 1'b0};
         step();
         step();
         checks++;
         if (state_o !== 3'd3 || outs !== exp) begin
            fails++; $display("FAIL br_exec_f3_%0d: state=%0d outs=%b want state=3 outs=%b", f3_tab[i], state_o, outs, exp);
         end
         step();
      end
      checks++;
      if (state_o !== 3'd1) begin
         fails++; $display("FAIL br_next_fetch: state=%0d want 1", state_o);
      end
   endtask

   task automatic test_reset_mid();
      opcode = 7'b0000011; funct3 = 3'd3;
      step();
      step();
      reset = 1'b1;
      step();
      checks++;
      if (state_o !== 3'd0 || outs !== E_QUIET) begin
         fails++; $display("FAIL rst_mid_exec: state=%0d outs=%b want state=0 outs=%b", state_o, outs, E_QUIET);
      end
      reset = 1'b0;
      step();
      checks++;
      if (state_o !== 3'd1 || outs !== E_FETCH) begin
         fails++; $display("FAIL rst_mid_fetch: state=%0d outs=%b want state=1 outs=%b", state_o, outs, E_FETCH);
      end
   endtask

`ifdef UC_HALT_ON_ILLEGAL_EN
   task automatic test_illegal();
      opcode = 7'b1111111; funct3 = 3'd0;
      step();
      for (int i = 0; i < 4; i++) begin
         step();
         checks++;
         if (state_o !== 3'd5 || outs !== E_HALT) begin
            fails++; $display("FAIL halt_hold_%0d: state=%0d outs=%b want state=5 outs=%b", i, state_o, outs, E_HALT);
         end
      end
      reset = 1'b1;
      step();
      checks++;
      if (state_o !== 3'd0 || outs !== E_QUIET) begin
         fails++; $display("FAIL halt_reset: state=%0d outs=%b want state=0 outs=%b", state_o, outs, E_QUIET);
      end
      reset = 1'b0;
      step();
      checks++;
      if (state_o !== 3'd1 || outs !== E_FETCH) begin
         fails++; $display("FAIL halt_refetch: state=%0d outs=%b want state=1 outs=%b", state_o, outs, E_FETCH);
      end
   endtask
`else
   task automatic test_illegal();
      logic [6:0] op_tab [4];
      logic [2:0] f3_tab [4];
      op_tab[0] = 7'b1111111; f3_tab[0] = 3'd0;
      op_tab[1] = 7'b0000011; f3_tab[1] = 3'd2;
      op_tab[2] = 7'b1100011; f3_tab[2] = 3'd2;
      op_tab[3] = 7'b0100011; f3_tab[3] = 3'd0;
      for (int i = 0; i < 4; i++) begin
         opcode = op_tab[i]; funct3 = f3_tab[i];
         step();
         step();
         checks++;
         if (state_o !== 3'd3 || outs !== E_NOP) begin
            fails++; $display("FAIL nop_exec_%0d: state=%0d outs=%b want state=3 outs=%b", i, state_o, outs, E_NOP);
         end
         step();
         checks++;
         if (state_o !== 3'd1 || outs !== E_FETCH) begin
            fails++; $display("FAIL nop_next_fetch_%0d: state=%0d outs=%b want state=1 outs=%b", i, state_o, outs, E_FETCH);
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_load();
      test_op_latch();
      test_store_addi();
      test_branch();
      test_reset_mid();
      test_illegal();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
